// File: rtl/kv_plru_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kv_plru_pkg
//  Description : Shared helpers for the tree pseudo-LRU engine. The helpers
//                work on maximum-size vectors (32 ways, 31 tree nodes) so
//                that any associativity from 2 to 32 can use them.
//                  - onehot_to_idx : one-hot to index, lowest set bit wins
//                  - child_node    : heap step from a node to its child
//                  - range_mask    : way mask covered by a subtree
//                  - tree_update   : mark a way MRU in a tree
//  Revision    : 1.0 - initial release
// ============================================================================
package kv_plru_pkg;

    localparam int c_MAX_WAYS   = 32;
    localparam int c_MAX_LEVELS = 5;
    localparam int c_MAX_NODES  = c_MAX_WAYS - 1;

    // Index of the lowest set bit. An all-zero input returns 0, so callers
    // must qualify the input with a non-zero check.
    function automatic logic [4:0] onehot_to_idx(input logic [c_MAX_WAYS-1:0] oh);
        logic [4:0]            idx;
        logic [c_MAX_WAYS-1:0] sh;
        idx = '0;
        for (int i = c_MAX_WAYS - 1; i >= 0; i--) begin
            sh = oh >> i;
            if (sh[0]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    // Heap ordering: the children of node n are 2n+1 (left) and 2n+2 (right).
    function automatic int child_node(input int node, input logic go_right);
        return 2 * node + 1 + int'(go_right);
    endfunction

    // Mask of the ways lo .. lo+size-1, i.e. the ways under one subtree.
    function automatic logic [c_MAX_WAYS-1:0] range_mask(input int lo, input int size);
        return ((32'd1 << size) - 32'd1) << lo;
    endfunction

    // Walk the root-to-leaf path of 'way' and point every node away from it.
    // A node bit of 1 means the victim lies in the right subtree, so a way in
    // the left subtree writes 1 and a way in the right subtree writes 0.
    function automatic logic [c_MAX_NODES-1:0] tree_update(
        input logic [c_MAX_NODES-1:0] tree,
        input logic [4:0]             way,
        input int                     levels
    );
        logic [c_MAX_NODES-1:0] t;
        logic [4:0]             wb;
        int                     node;
        t    = tree;
        node = 0;
        for (int l = 0; l < c_MAX_LEVELS; l++) begin
            if (l < levels) begin
                // Way-index bit for this level: 0 = left half, 1 = right half.
                wb   = way >> (levels - 1 - l);
                t    = (t & ~(31'd1 << node)) | ({30'd0, ~wb[0]} << node);
                node = child_node(node, wb[0]);
            end
        end
        return t;
    endfunction

endpackage : kv_plru_pkg
`default_nettype wire

// File: rtl/kv_plru_select.sv
`default_nettype none
// ============================================================================
//  Module      : kv_plru_select
//  Description : Combinational victim selection for one set.
//                Priority: lowest free (invalid, unlocked) way; otherwise a
//                tree walk that steers around fully locked subtrees;
//                otherwise (everything locked) none=1 and way=0.
//  Ports       : tree      - PLRU node bits, heap ordered
//                validmask - 1 = way holds a valid line
//                lockmask  - 1 = way may not be chosen
//                way       - one-hot victim
//                none      - every way is locked
//  Revision    : 1.0 - initial release
// ============================================================================
module kv_plru_select
    import kv_plru_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0] tree,
    input  logic [NUM_WAYS-1:0] validmask,
    input  logic [NUM_WAYS-1:0] lockmask,
    output logic [NUM_WAYS-1:0] way,
    output logic                none
);

    localparam int                  c_LEVELS = $clog2(NUM_WAYS);
    localparam logic [NUM_WAYS-1:0] c_ONE    = {{(NUM_WAYS-1){1'b0}}, 1'b1};

    logic [NUM_WAYS-1:0]   w_free;
    logic [c_MAX_WAYS-1:0] w_lock32;

    assign w_free   = ~validmask & ~lockmask;
    assign w_lock32 = 32'(lockmask);

    always_comb begin
        logic [NUM_WAYS-2:0]   node_bits;
        logic [c_MAX_WAYS-1:0] lmask;
        logic [c_MAX_WAYS-1:0] rmask;
        logic                  left_locked;
        logic                  right_locked;
        logic                  go_right;
        int                    node;
        int                    lo;
        int                    half;

        way          = '0;
        none         = 1'b0;
        node_bits    = '0;
        lmask        = '0;
        rmask        = '0;
        left_locked  = 1'b0;
        right_locked = 1'b0;
        go_right     = 1'b0;
        node         = 0;
        lo           = 0;
        half         = 0;

        if (&lockmask) begin
            none = 1'b1;
        end else if (|w_free) begin
            // Isolate the lowest set bit.
            way = w_free & (~w_free + c_ONE);
        end else begin
            // Not everything is locked, so at every node at least one child
            // subtree still holds an unlocked way; the walk cannot dead-end.
            for (int l = 0; l < c_LEVELS; l++) begin
                half         = NUM_WAYS >> (l + 1);
                lmask        = range_mask(lo, half);
                rmask        = range_mask(lo + half, half);
                left_locked  = ((w_lock32 & lmask) == lmask);
                right_locked = ((w_lock32 & rmask) == rmask);
                node_bits    = tree >> node;
                go_right     = node_bits[0] ? ~right_locked : left_locked;
                if (go_right) begin
                    lo = lo + half;
                end
                node = child_node(node, go_right);
            end
            way = c_ONE << lo;
        end
    end

endmodule : kv_plru_select
`default_nettype wire

// File: rtl/kv_tree_plru.sv
`default_nettype none
// ============================================================================
//  Module      : kv_tree_plru
//  Description : Tree pseudo-LRU replacement engine, one tree per set.
//                Hit/fill updates are written at the end of their cycle;
//                victim lookups return a registered one-hot way one cycle
//                later. Lookups see same-cycle writes (fill, then update).
//                With UPDATE_ON_VICTIM=1 every returned victim is marked MRU
//                in the cycle its result is presented.
//  Ports       : i_clk, i_rst            - clock, sync active-high reset
//                i_upd_valid/index/way   - access to record (one-hot way)
//                i_vic_req/index         - victim lookup request
//                i_vic_validmask/lockmask- per-way valid and lock state
//                o_vic_valid/way/none    - registered lookup result
//  Revision    : 1.0 - initial release
// ============================================================================
module kv_tree_plru
    import kv_plru_pkg::*;
#(
    parameter int  NUM_WAYS         = 4,
    parameter int  NUM_SETS         = 16,
    parameter bit  UPDATE_ON_VICTIM = 1'b0,
    localparam int IDX_W            = $clog2(NUM_SETS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_upd_valid,
    input  logic [IDX_W-1:0]    i_upd_index,
    input  logic [NUM_WAYS-1:0] i_upd_way,
    input  logic                i_vic_req,
    input  logic [IDX_W-1:0]    i_vic_index,
    input  logic [NUM_WAYS-1:0] i_vic_validmask,
    input  logic [NUM_WAYS-1:0] i_vic_lockmask,
    output logic                o_vic_valid,
    output logic [NUM_WAYS-1:0] o_vic_way,
    output logic                o_vic_none
);

    localparam int c_LEVELS = $clog2(NUM_WAYS);

    logic [NUM_WAYS-2:0] r_tree [NUM_SETS];
    logic                r_vic_valid;
    logic [NUM_WAYS-1:0] r_vic_way;
    logic                r_vic_none;
    logic [IDX_W-1:0]    r_vic_index;

    logic                   w_fill_active;
    logic                   w_upd_active;
    logic [c_MAX_NODES-1:0] w_fill_new;
    logic [c_MAX_NODES-1:0] w_upd_base;
    logic [c_MAX_NODES-1:0] w_upd_new;
    logic [c_MAX_NODES-1:0] w_look;
    logic [NUM_WAYS-1:0]    w_sel_way;
    logic                   w_sel_none;
    logic                   w_unused;

    // The result currently on the outputs is the fill target.
    assign w_fill_active = UPDATE_ON_VICTIM && r_vic_valid && !r_vic_none;
    assign w_upd_active  = i_upd_valid && (|i_upd_way);

    always_comb begin
        logic [c_MAX_NODES-1:0] fill_base;
        fill_base                 = '0;
        fill_base[NUM_WAYS-2:0]   = r_tree[r_vic_index];
        w_fill_new                = tree_update(fill_base,
                                                onehot_to_idx(32'(r_vic_way)),
                                                c_LEVELS);

        // An update to the set being filled builds on the filled tree so
        // that the update wins on shared nodes.
        w_upd_base                = '0;
        w_upd_base[NUM_WAYS-2:0]  = r_tree[i_upd_index];
        if (w_fill_active && (r_vic_index == i_upd_index)) begin
            w_upd_base = w_fill_new;
        end
        w_upd_new                 = tree_update(w_upd_base,
                                                onehot_to_idx(32'(i_upd_way)),
                                                c_LEVELS);

        // Lookup forwarding. w_upd_new already contains the fill whenever
        // the fill and the update share the lookup's set.
        w_look                    = '0;
        w_look[NUM_WAYS-2:0]      = r_tree[i_vic_index];
        if (w_fill_active && (r_vic_index == i_vic_index)) begin
            w_look = w_fill_new;
        end
        if (w_upd_active && (i_upd_index == i_vic_index)) begin
            w_look = w_upd_new;
        end
    end

    // Upper bits of the max-size helper vectors are always zero here.
    assign w_unused = ^{w_fill_new, w_upd_new, w_look};

    kv_plru_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_select (
        .tree      (w_look[NUM_WAYS-2:0]),
        .validmask (i_vic_validmask),
        .lockmask  (i_vic_lockmask),
        .way       (w_sel_way),
        .none      (w_sel_none)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_tree[s] <= '0;
            end
            r_vic_valid <= 1'b0;
            r_vic_way   <= '0;
            r_vic_none  <= 1'b0;
            r_vic_index <= '0;
        end else begin
            // When both target one set the second write carries both effects.
            if (w_fill_active) begin
                r_tree[r_vic_index] <= w_fill_new[NUM_WAYS-2:0];
            end
            if (w_upd_active) begin
                r_tree[i_upd_index] <= w_upd_new[NUM_WAYS-2:0];
            end
            r_vic_valid <= i_vic_req;
            r_vic_way   <= i_vic_req ? w_sel_way : '0;
            r_vic_none  <= i_vic_req && w_sel_none;
            r_vic_index <= i_vic_index;
        end
    end

    assign o_vic_valid = r_vic_valid;
    assign o_vic_way   = r_vic_way;
    assign o_vic_none  = r_vic_none;

endmodule : kv_tree_plru
`default_nettype wire

// File: tb/tb_kv_tree_plru.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kv_tree_plru
//  Description : Self-checking bench for kv_tree_plru. Two instances share
//                the stimulus: one plain, one with fill-on-victim. A
//                directed vector table covers the documented scenarios, then
//                random traffic is compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kv_tree_plru;

    localparam int NW = 4;
    localparam int NS = 16;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd_valid;
    logic [3:0]    upd_index;
    logic [NW-1:0] upd_way;
    logic          vic_req;
    logic [3:0]    vic_index;
    logic [NW-1:0] vic_vm;
    logic [NW-1:0] vic_lm;
    logic          v0, v1, n0, n1;
    logic [NW-1:0] w0, w1;

    always #5 clk = ~clk;

    kv_tree_plru #(.NUM_WAYS(NW), .NUM_SETS(NS), .UPDATE_ON_VICTIM(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_upd_valid(upd_valid), .i_upd_index(upd_index), .i_upd_way(upd_way),
        .i_vic_req(vic_req), .i_vic_index(vic_index),
        .i_vic_validmask(vic_vm), .i_vic_lockmask(vic_lm),
        .o_vic_valid(v0), .o_vic_way(w0), .o_vic_none(n0)
    );

    kv_tree_plru #(.NUM_WAYS(NW), .NUM_SETS(NS), .UPDATE_ON_VICTIM(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_upd_valid(upd_valid), .i_upd_index(upd_index), .i_upd_way(upd_way),
        .i_vic_req(vic_req), .i_vic_index(vic_index),
        .i_vic_validmask(vic_vm), .i_vic_lockmask(vic_lm),
        .o_vic_valid(v1), .o_vic_way(w1), .o_vic_none(n1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: per instance, per set, one bit per tree node.
    logic [2:0]    mt [2][NS];
    logic          ev [2];
    logic [NW-1:0] ew [2];
    logic          en [2];
    int            es [2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lowbit(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Node at depth l on way w's path is (2^l - 1) + (w >> (L-l)); its
    // new value is 1 when w sits in that node's left half.
    function automatic logic [2:0] m_touch(input logic [2:0] t, input int w);
        logic [2:0] r;
        r = t;
        for (int l = 0; l < L; l++) begin
            int node;
            node    = (1 << l) - 1 + (w >> (L - l));
            r[node] = (((w >> (L - l - 1)) & 1) == 0);
        end
        return r;
    endfunction

    function automatic bit all_locked(input logic [NW-1:0] lm, input int lo, input int n);
        for (int i = lo; i < lo + n; i++) begin
            if (!lm[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_victim(input logic [2:0] t, input logic [NW-1:0] vm,
                                     input logic [NW-1:0] lm,
                                     output logic [NW-1:0] way, output logic none);
        int lo, size, node;
        bit gr;
        way  = '0;
        none = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (!vm[w] && !lm[w]) begin
                way = NW'(1 << w);
                return;
            end
        end
        if (lm == '1) begin
            none = 1'b1;
            return;
        end
        lo = 0; size = NW; node = 0;
        while (size > 1) begin
            int half;
            half = size / 2;
            gr   = t[node] ? !all_locked(lm, lo + half, half) : all_locked(lm, lo, half);
            node = 2 * node + 1 + (gr ? 1 : 0);
            if (gr) lo = lo + half;
            size = half;
        end
        way = NW'(1 << lo);
    endfunction

    // One clock cycle: drive, advance the model, clock, compare both DUTs.
    task automatic cycle(input bit r, input bit uv, input int ui, input logic [NW-1:0] uw,
                         input bit rq, input int vi, input logic [NW-1:0] vmk,
                         input logic [NW-1:0] lmk);
        logic [NW-1:0] xw [2];
        logic          xn [2];
        rst       = r;
        upd_valid = uv;
        upd_index = 4'(ui);
        upd_way   = uw;
        vic_req   = rq;
        vic_index = 4'(vi);
        vic_vm    = vmk;
        vic_lm    = lmk;
        for (int k = 0; k < 2; k++) begin
            bit         fill;
            int         uwi;
            logic [2:0] t;
            fill = (k == 1) && ev[k] && !en[k];
            uwi  = uv ? lowbit(uw) : -1;
            t    = mt[k][vi];
            if (fill && es[k] == vi) t = m_touch(t, lowbit(ew[k]));
            if (uwi >= 0 && ui == vi) t = m_touch(t, uwi);
            m_victim(t, vmk, lmk, xw[k], xn[k]);
            if (r) begin
                for (int s = 0; s < NS; s++) mt[k][s] = '0;
                ev[k] = 1'b0; ew[k] = '0; en[k] = 1'b0; es[k] = 0;
            end else begin
                if (fill) mt[k][es[k]] = m_touch(mt[k][es[k]], lowbit(ew[k]));
                if (uwi >= 0) mt[k][ui] = m_touch(mt[k][ui], uwi);
                ev[k] = rq;
                ew[k] = rq ? xw[k] : '0;
                en[k] = rq && xn[k];
                es[k] = vi;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("dut0 vic_valid", int'(v0), int'(ev[0]));
        chk("dut0 vic_way",   int'(w0), int'(ew[0]));
        chk("dut0 vic_none",  int'(n0), int'(en[0]));
        chk("dut1 vic_valid", int'(v1), int'(ev[1]));
        chk("dut1 vic_way",   int'(w1), int'(ew[1]));
        chk("dut1 vic_none",  int'(n1), int'(en[1]));
    endtask

    typedef struct {
        bit            r;
        bit            uv;
        int            ui;
        logic [NW-1:0] uw;
        bit            rq;
        int            vi;
        logic [NW-1:0] vm;
        logic [NW-1:0] lm;
        int            dut;   // instance whose outputs are checked, -1 = none
        bit            xv;
        logic [NW-1:0] xw;
        bit            xn;
    } vec_t;

    vec_t tbl [22];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NS; s++) mt[k][s] = '0;
            ev[k] = 1'b0; ew[k] = '0; en[k] = 1'b0; es[k] = 0;
        end
        //           r  uv ui uw     rq vi vm     lm     dut xv xw     xn
        tbl[0]  = '{1, 0, 0, 4'h0, 0, 0, 4'hF, 4'h0,  0, 0, 4'h0, 0}; // reset state
        tbl[1]  = '{1, 0, 0, 4'h0, 0, 0, 4'hF, 4'h0,  1, 0, 4'h0, 0};
        tbl[2]  = '{0, 0, 0, 4'h0, 1, 1, 4'hF, 4'h0,  0, 1, 4'h1, 0}; // fresh set
        tbl[3]  = '{0, 0, 0, 4'h0, 1, 2, 4'hB, 4'h0,  0, 1, 4'h4, 0}; // invalid way
        tbl[4]  = '{0, 0, 0, 4'h0, 1, 2, 4'hB, 4'h4,  0, 1, 4'h1, 0}; // invalid but locked
        tbl[5]  = '{0, 1, 3, 4'h1, 0, 0, 4'hF, 4'h0,  0, 0, 4'h0, 0};
        tbl[6]  = '{0, 1, 3, 4'h2, 0, 0, 4'hF, 4'h0, -1, 0, 4'h0, 0};
        tbl[7]  = '{0, 1, 3, 4'h4, 0, 0, 4'hF, 4'h0, -1, 0, 4'h0, 0};
        tbl[8]  = '{0, 1, 3, 4'h8, 0, 0, 4'hF, 4'h0, -1, 0, 4'h0, 0};
        tbl[9]  = '{0, 0, 0, 4'h0, 1, 3, 4'hF, 4'h0,  0, 1, 4'h1, 0}; // after 0,1,2,3
        tbl[10] = '{0, 1, 3, 4'h1, 0, 0, 4'hF, 4'h0, -1, 0, 4'h0, 0};
        tbl[11] = '{0, 0, 0, 4'h0, 1, 3, 4'hF, 4'h0,  0, 1, 4'h4, 0};
        tbl[12] = '{0, 1, 5, 4'h1, 1, 5, 4'hF, 4'h0,  0, 1, 4'h4, 0}; // same-cycle fwd
        tbl[13] = '{0, 1, 5, 4'h1, 1, 6, 4'hF, 4'h0,  0, 1, 4'h1, 0}; // cross-set
        tbl[14] = '{0, 0, 0, 4'h0, 1, 8, 4'hF, 4'h5,  0, 1, 4'h2, 0}; // locks
        tbl[15] = '{0, 0, 0, 4'h0, 1, 8, 4'hF, 4'hF,  0, 1, 4'h0, 1};
        tbl[16] = '{0, 0, 0, 4'h0, 1, 8, 4'hF, 4'h3,  0, 1, 4'h4, 0};
        tbl[17] = '{0, 0, 0, 4'h0, 1, 7, 4'hF, 4'h0,  1, 1, 4'h1, 0}; // fill-on-victim
        tbl[18] = '{0, 0, 0, 4'h0, 1, 7, 4'hF, 4'h0,  1, 1, 4'h4, 0};
        tbl[19] = '{0, 0, 0, 4'h0, 1, 7, 4'hF, 4'h0,  1, 1, 4'h2, 0};
        tbl[20] = '{1, 0, 0, 4'h0, 1, 7, 4'hF, 4'h0,  1, 0, 4'h0, 0}; // reset drops req
        tbl[21] = '{0, 0, 0, 4'h0, 1, 7, 4'hF, 4'h0,  1, 1, 4'h1, 0};

        for (int i = 0; i < 22; i++) begin
            logic          av, an;
            logic [NW-1:0] aw;
            cycle(tbl[i].r, tbl[i].uv, tbl[i].ui, tbl[i].uw, tbl[i].rq, tbl[i].vi,
                  tbl[i].vm, tbl[i].lm);
            if (tbl[i].dut >= 0) begin
                av = (tbl[i].dut == 0) ? v0 : v1;
                aw = (tbl[i].dut == 0) ? w0 : w1;
                an = (tbl[i].dut == 0) ? n0 : n1;
                chk($sformatf("vec%0d valid", i), int'(av), int'(tbl[i].xv));
                chk($sformatf("vec%0d way",   i), int'(aw), int'(tbl[i].xw));
                chk($sformatf("vec%0d none",  i), int'(an), int'(tbl[i].xn));
            end
        end

        // Random traffic concentrated on a few sets to force collisions.
        for (int i = 0; i < 3000; i++) begin
            logic [NW-1:0] vm, lm;
            vm = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '1;
            lm = NW'($urandom) & NW'($urandom);
            if ($urandom_range(0, 15) == 0) lm = '1;
            cycle($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), NW'($urandom),
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), vm, lm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_kv_tree_plru
`default_nettype wire

// File: doc/kv_tree_plru.md
# kv_tree_plru

Parametrised tree pseudo-LRU replacement engine for the set-associative caches. It is the generalised successor of the fixed 4-way LRU kill-mask block. It keeps one PLRU tree per set and accepts hit/fill updates. On request it returns a registered one-hot victim way, with these selection rules applied:
- invalid ways are preferred;
- locked ways are skipped;
- same-cycle updates are forwarded;
- a fill-on-victim mode is available.

## Interface
Parameters:
- NUM_WAYS, 4, associativity; power of two, 2..32
- NUM_SETS, 16, number of sets; power of two, ≥2
- UPDATE_ON_VICTIM, 0, 1 = a returned victim is automatically marked MRU (fill)
- IDX_W, $clog2(NUM_SETS), derived, not overridable

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_upd_valid  in  1  record an access this cycle
- i_upd_index  in  IDX_W  set of the access
- i_upd_way  in  NUM_WAYS  one-hot hit way
- i_vic_req  in  1  victim lookup request
- i_vic_index  in  IDX_W  set to look up
- i_vic_validmask  in  NUM_WAYS  1 = way holds valid line
- i_vic_lockmask  in  NUM_WAYS  1 = way must not be chosen
- o_vic_valid  out  1  victim result valid (one-cycle pulse)
- o_vic_way  out  NUM_WAYS  one-hot victim (kill mask)
- o_vic_none  out  1  all ways locked; o_vic_way is 0

## Operation
- State: NUM_SETS × (NUM_WAYS−1) tree bits, heap-ordered (node 0 = root; children of node n are 2n+1 and 2n+2). Bit 0 = victim lies in the left (lower-index) subtree.
- Update (access to way w): every node on w's root-to-leaf path is set to point away from w (w in left subtree → bit 1). Other nodes are unchanged.
- i_upd_way = 0: the update is ignored. Multiple bits set: the lowest set bit is used.
- Victim selection, in priority order:
  1. The lowest-index way with validmask=0 and lockmask=0.
  2. Otherwise, a tree walk from the root. At each node, follow the bit unless every way in that subtree is locked; in that case take the sibling.
  3. If all ways are locked: o_vic_none=1 and o_vic_way=0.
- Forwarding: a lookup in cycle N on set s sees the tree for s with all of the following applied, in this order:
  - the fill write committing in cycle N (UPDATE_ON_VICTIM=1);
  - the i_upd write of cycle N.
- Fill (UPDATE_ON_VICTIM=1): when o_vic_valid=1 and o_vic_none=0, the victim's path is written at the end of that cycle. If i_upd targets the same set in that cycle, the fill is applied first and i_upd second, so i_upd wins on shared nodes.
- Independent sets never interact.

## Timing
- Reset values:
  - all tree bits 0, so a fresh set's victim is way 0;
  - o_vic_valid=0, o_vic_way=0, o_vic_none=0.
- Lookup latency is 1 cycle. i_vic_req in cycle N gives o_vic_valid=1 in cycle N+1, with o_vic_way and o_vic_none held only for that cycle.
- Back-to-back requests are accepted every cycle. There is no backpressure.
- Updates take effect at the clock edge ending the cycle they are presented in.
- i_rst asserted in cycle N:
  - any request from cycle N−1 produces no o_vic_valid in N+1;
  - no fill is performed;
  - i_upd and i_vic_req in cycle N are dropped.

## Structure
- Package kv_plru_pkg holds:
  - the function that maps a tree path to nodes and way ranges;
  - the update function (tree, way → tree);
  - a onehot-to-index function with lowest-bit priority.
- One sub-module, kv_plru_select, is combinational. It takes tree bits, validmask and lockmask and produces the one-hot way and the none flag. Its output feeds the output register in the top.
- The top contains the state array, the forwarding muxes, the fill logic and the output flops.

## Test plan
All scenarios use NUM_WAYS=4 and NUM_SETS=16 unless stated.
1. Reset, then lookup set 1 with validmask 1111 and lockmask 0000 → next cycle o_vic_valid=1, o_vic_way=0001.
2. Lookup on a fresh set with validmask 1011 → 0100. Repeat with lockmask 0100 → 0001 (tree walk).
3. Updates on set 3 with ways 0001, 0010, 0100, 1000, then a lookup → 0001. Then update 0001 and look up again → 0100.
4. Forwarding:
   - same cycle: update set 5 way 0001 plus lookup set 5 → 0100;
   - cross-set: update set 5 plus lookup set 6 → 0001.
5. Locks on a fresh set:
   - lockmask 0101 → 0010;
   - lockmask 1111 → o_vic_none=1, o_vic_way=0000;
   - lockmask 0011 → 0100.
6. UPDATE_ON_VICTIM=1, back-to-back lookups on fresh set 7 → 0001, then 0100. Then assert i_rst while a request is in flight → no o_vic_valid pulse, and a post-reset lookup on set 7 → 0001.
